mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 47 ++++
 rtl/mc_controller_outdec.sv | 60 ++++++
 rtl/mc_controller.sv | 102 ++++++++++
 tb/tb_mc_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes
// and the bundled control-output record.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       branch;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_controller_outdec.sv
// Per-state control output decode. Unused state encodings decode to all-zero
// so a corrupted state register cannot fire a write strobe.
module mc_outdec
    import mc_controller_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb = 2'b01;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: ctrl.alusrcb = 2'b11;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b01;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU main controller: state register, next-state logic and
// output wiring around the mc_outdec decoder.
//
// state     | meaning
// FETCH     | read instruction, PC+4; waits on mem_ready
// DECODE    | register read, branch target compute
// MEMADR    | effective address for lw/sw
// MEMRD     | data memory read; waits on mem_ready
// MEMWB     | load result to register file
// MEMWR     | data memory write; waits on mem_ready
// RTYPEEX   | ALU operation per funct
// RTYPEWB   | ALU result to rd
// BEQEX     | compare and conditional PC update
// ADDIEX    | rs + immediate
// ADDIWB    | ALU result to rt
// JEX       | jump target to PC
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       alusrca,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       branch,
    output logic       pcwrite,
    output logic       pcen,
    output logic       illegal_op,
    output logic [1:0] pcsrc,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop
);

    if (STATE_W != 4) begin : g_state_w_check
        $error("mc_controller: STATE_W must be 4");
    end

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign iord       = ctrl.iord;
    assign alusrca    = ctrl.alusrca;
    assign irwrite    = ctrl.irwrite;
    assign memwrite   = ctrl.memwrite;
    assign regwrite   = ctrl.regwrite;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign branch     = ctrl.branch;
    assign pcwrite    = ctrl.pcwrite;
    assign pcsrc      = ctrl.pcsrc;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    // Branch resolution must reach the PC enable in the same cycle as zero.
    assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
    assign illegal_op = (state_q == S_DECODE) && !op_legal(op);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each cycle pushes the expected output
// vector for the intended state and compares it at the falling edge.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg;
    logic       branch, pcwrite, pcen, illegal_op;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic [16:0] obs;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];
    string       tag_q[$];

    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] OP_BAD2 = 6'b000001;

    always #5 clk = ~clk;

    mc_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .alusrca    (alusrca),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .branch     (branch),
        .pcwrite    (pcwrite),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .pcsrc      (pcsrc),
        .alusrcb    (alusrcb),
        .aluop      (aluop)
    );

    assign obs = {iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg,
                  branch, pcwrite, pcen, illegal_op, pcsrc, alusrcb, aluop};

    function automatic logic [16:0] expect_out(input state_t s, input logic [5:0] o,
                                               input logic mr, input logic z);
        logic e_iord, e_asa, e_irw, e_mw, e_rw, e_rd, e_m2r, e_br, e_pcw, e_pcen, e_ill;
        logic [1:0] e_pcsrc, e_asb, e_aluop;
        {e_iord, e_asa, e_irw, e_mw, e_rw, e_rd, e_m2r, e_br, e_pcw} = '0;
        e_pcsrc = 2'b00;
        e_asb   = 2'b00;
        e_aluop = 2'b00;
        case (s)
            S_FETCH:   begin e_asb = 2'b01; e_irw = mr; e_pcw = mr; end
            S_DECODE:  e_asb = 2'b11;
            S_MEMADR:  begin e_asa = 1'b1; e_asb = 2'b10; end
            S_MEMRD:   e_iord = 1'b1;
            S_MEMWB:   begin e_m2r = 1'b1; e_rw = 1'b1; end
            S_MEMWR:   begin e_iord = 1'b1; e_mw = 1'b1; end
            S_RTYPEEX: begin e_asa = 1'b1; e_aluop = 2'b10; end
            S_RTYPEWB: begin e_rd = 1'b1; e_rw = 1'b1; end
            S_BEQEX:   begin e_asa = 1'b1; e_aluop = 2'b01; e_pcsrc = 2'b01; e_br = 1'b1; end
            S_ADDIEX:  begin e_asa = 1'b1; e_asb = 2'b10; end
            S_ADDIWB:  e_rw = 1'b1;
            S_JEX:     begin e_pcsrc = 2'b10; e_pcw = 1'b1; end
            default:   e_asb = 2'b00;
        endcase
        e_pcen = e_pcw | (e_br & z);
        e_ill  = (s == S_DECODE) &&
                 !(o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
        return {e_iord, e_asa, e_irw, e_mw, e_rw, e_rd, e_m2r, e_br, e_pcw, e_pcen,
                e_ill, e_pcsrc, e_asb, e_aluop};
    endfunction

    // One clock cycle in which the DUT is expected to sit in state s.
    task automatic cyc(input state_t s, input logic [5:0] o, input logic mr,
                       input logic z, input logic r);
        logic [16:0] e;
        string       t;
        op        = o;
        mem_ready = mr;
        zero      = z;
        rst       = r;
        exp_q.push_back(expect_out(s, o, mr, z));
        tag_q.push_back($sformatf("%s#%0d", s.name(), checks));
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        op        = OP_RTYPE;
        zero      = 1'b0;
        mem_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // reset state with memory not ready, then a FETCH stall
        cyc(S_FETCH,   OP_LW, 1'b0, 1'b0, 1'b0);
        cyc(S_FETCH,   OP_LW, 1'b0, 1'b0, 1'b0);

        // lw, memory always ready
        cyc(S_FETCH,   OP_LW, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_LW, 1'b1, 1'b0, 1'b0);
        cyc(S_MEMADR,  OP_LW, 1'b1, 1'b0, 1'b0);
        cyc(S_MEMRD,   OP_LW, 1'b1, 1'b0, 1'b0);
        cyc(S_MEMWB,   OP_LW, 1'b1, 1'b0, 1'b0);

        // lw with a MEMRD wait; DECODE/MEMADR ignore mem_ready
        cyc(S_FETCH,   OP_LW, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_LW, 1'b0, 1'b0, 1'b0);
        cyc(S_MEMADR,  OP_LW, 1'b0, 1'b0, 1'b0);
        cyc(S_MEMRD,   OP_LW, 1'b0, 1'b0, 1'b0);
        cyc(S_MEMRD,   OP_LW, 1'b1, 1'b0, 1'b0);
        cyc(S_MEMWB,   OP_LW, 1'b0, 1'b0, 1'b0);

        // sw with two wait cycles in MEMWR
        cyc(S_FETCH,   OP_SW, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_SW, 1'b1, 1'b0, 1'b0);
        cyc(S_MEMADR,  OP_SW, 1'b1, 1'b0, 1'b0);
        cyc(S_MEMWR,   OP_SW, 1'b0, 1'b0, 1'b0);
        cyc(S_MEMWR,   OP_SW, 1'b0, 1'b0, 1'b0);
        cyc(S_MEMWR,   OP_SW, 1'b1, 1'b0, 1'b0);

        // beq taken, then not taken; zero high in DECODE must not move the PC
        cyc(S_FETCH,   OP_BEQ, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_BEQ, 1'b1, 1'b1, 1'b0);
        cyc(S_BEQEX,   OP_BEQ, 1'b1, 1'b1, 1'b0);
        cyc(S_FETCH,   OP_BEQ, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_BEQ, 1'b1, 1'b0, 1'b0);
        cyc(S_BEQEX,   OP_BEQ, 1'b1, 1'b0, 1'b0);

        // unrecognised opcodes
        cyc(S_FETCH,   OP_BAD, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_BAD, 1'b1, 1'b0, 1'b0);
        cyc(S_FETCH,   OP_BAD2, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_BAD2, 1'b1, 1'b0, 1'b0);

        // R-type aborted by reset in RTYPEEX
        cyc(S_FETCH,   OP_RTYPE, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_RTYPE, 1'b1, 1'b0, 1'b0);
        cyc(S_RTYPEEX, OP_RTYPE, 1'b1, 1'b0, 1'b1);
        cyc(S_FETCH,   OP_RTYPE, 1'b0, 1'b0, 1'b0);

        // R-type to completion followed by j
        cyc(S_FETCH,   OP_RTYPE, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_RTYPE, 1'b1, 1'b0, 1'b0);
        cyc(S_RTYPEEX, OP_RTYPE, 1'b1, 1'b0, 1'b0);
        cyc(S_RTYPEWB, OP_RTYPE, 1'b1, 1'b0, 1'b0);
        cyc(S_FETCH,   OP_J, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_J, 1'b1, 1'b0, 1'b0);
        cyc(S_JEX,     OP_J, 1'b0, 1'b0, 1'b0);

        // addi, then reset during FETCH
        cyc(S_FETCH,   OP_ADDI, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_ADDI, 1'b0, 1'b0, 1'b0);
        cyc(S_ADDIEX,  OP_ADDI, 1'b0, 1'b1, 1'b0);
        cyc(S_ADDIWB,  OP_ADDI, 1'b0, 1'b0, 1'b0);
        cyc(S_FETCH,   OP_ADDI, 1'b1, 1'b0, 1'b1);
        cyc(S_FETCH,   OP_ADDI, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  OP_ADDI, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
